// File: rtl/raw_arb_pkg.sv
// Shared definitions for the two-requester raw-data FIFO arbiter.
// State encodings, parameter defaults and the arbitration pick helper.
package raw_arb_pkg;

   localparam int unsigned RAW_DATA_W_DEF  = 32;
   localparam int unsigned RAW_TIMEOUT_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_GNT_0 = 3'b010,
      ST_GNT_1 = 3'b100
   } raw_arb_state_e;

   // On a tie the requester not named by rr_ptr wins.
   function automatic raw_arb_state_e arb_pick(input logic i_req_0,
                                                input logic i_req_1,
                                                input logic i_rr_ptr);
      if (i_req_0 && i_req_1) begin
         return i_rr_ptr ? ST_GNT_0 : ST_GNT_1;
      end else if (i_req_0) begin
         return ST_GNT_0;
      end else if (i_req_1) begin
         return ST_GNT_1;
      end
      return ST_IDLE;
   endfunction

endpackage

// File: rtl/raw_arb_wdog.sv
// Idle-grant watchdog: counts granted cycles with no push and no back-pressure.
// Only instantiated when RAW_ARB_TIMEOUT_EN is defined.
module raw_arb_wdog
   import raw_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = RAW_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_active,
   input  logic i_restart,
   output logic o_expire
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LP_TERM = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   // Expiry fires on the cycle that would bring the count to TIMEOUT_CYCLES.
   assign o_expire = i_active && (r_cnt == LP_TERM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_restart) begin
         r_cnt <= '0;
      end else if (i_active) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/raw_fifo_arbiter.sv
// Round-robin arbiter funnelling two raw-data bursts into one shared FIFO.
// Optional idle-grant forced release under RAW_ARB_TIMEOUT_EN.
module raw_fifo_arbiter
   import raw_arb_pkg::*;
#(
   parameter int unsigned DATA_W         = RAW_DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = RAW_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_0,
   input  logic              req_1,
   input  logic              push_0,
   input  logic              push_1,
   input  logic              last_0,
   input  logic              last_1,
   input  logic [DATA_W-1:0] data_0,
   input  logic [DATA_W-1:0] data_1,
   output logic              gnt_0,
   output logic              gnt_1,
   output logic              full_0,
   output logic              full_1,
   input  logic              fifo_full,
   output logic              fifo_push,
   output logic [DATA_W-1:0] fifo_data,
   output logic              timeout
);

   raw_arb_state_e r_state;
   raw_arb_state_e w_state_nxt;
   logic           r_rr_ptr;
   logic           w_rr_nxt;

   logic w_gnt_0;
   logic w_gnt_1;
   logic w_cur_id;
   logic w_push_sel;
   logic w_last_sel;
   logic w_req_sel;
   logic w_accept_last;
   logic w_expire;

   assign w_gnt_0  = (r_state == ST_GNT_0);
   assign w_gnt_1  = (r_state == ST_GNT_1);
   assign w_cur_id = w_gnt_1;

   assign w_push_sel = (w_gnt_0 & push_0) | (w_gnt_1 & push_1);
   assign w_last_sel = (w_gnt_0 & last_0) | (w_gnt_1 & last_1);
   assign w_req_sel  = w_gnt_0 ? req_0 : req_1;

   assign gnt_0     = w_gnt_0;
   assign gnt_1     = w_gnt_1;
   assign fifo_push = w_push_sel & ~fifo_full;
   assign fifo_data = w_gnt_0 ? data_0 : (w_gnt_1 ? data_1 : '0);
   assign full_0    = w_gnt_0 ? fifo_full : 1'b1;
   assign full_1    = w_gnt_1 ? fifo_full : 1'b1;

   assign w_accept_last = fifo_push & w_last_sel;

`ifdef RAW_ARB_TIMEOUT_EN
   logic w_wdog_active;
   logic w_wdog_restart;
   logic r_timeout;

   assign w_wdog_active  = (w_gnt_0 | w_gnt_1) & ~fifo_full & ~w_push_sel;
   assign w_wdog_restart = fifo_push | (r_state == ST_IDLE) | (w_state_nxt != r_state);

   raw_arb_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk       (clk),
      .reset     (reset),
      .i_active  (w_wdog_active),
      .i_restart (w_wdog_restart),
      .o_expire  (w_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
      end
   end

   assign timeout = r_timeout;
`else
   logic w_unused_tmo;

   assign w_expire     = 1'b0;
   assign w_unused_tmo = ^TIMEOUT_CYCLES;
   assign timeout      = 1'b0;
`endif

   // Back-pressure freezes the grant; an accepted last re-arbitrates with no IDLE bubble.
   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = arb_pick(req_0, req_1, r_rr_ptr);
         end
         ST_GNT_0, ST_GNT_1: begin
            if (!fifo_full) begin
               if (w_accept_last) begin
                  w_rr_nxt    = w_cur_id;
                  w_state_nxt = arb_pick(req_0, req_1, w_cur_id);
               end else if (!w_req_sel || w_expire) begin
                  w_rr_nxt    = w_cur_id;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

endmodule

// File: doc/raw_fifo_arbiter.md
RAW_FIFO_ARBITER -- requirements
Module: raw_fifo_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, width of the raw data word.
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 16, idle-grant cycles before forced release (used only under RAW_ARB_TIMEOUT_EN).
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: req_0, req_1  in  1  per-requester bus request, held for the whole burst.
REQ-006 SHALL have ports: push_0, push_1  in  1  per-requester word-valid strobe.
REQ-007 SHALL have ports: last_0, last_1  in  1  marks the final word of a burst; qualified by push_n.
REQ-008 SHALL have ports: data_0, data_1  in  DATA_W  per-requester raw data word.
REQ-009 SHALL have ports: gnt_0, gnt_1  out  1  registered grant, one-hot or zero.
REQ-010 SHALL have ports: full_0, full_1  out  1  per-requester back-pressure.
REQ-011 SHALL have port: fifo_full  in  1  full flag of the shared raw_data_out FIFO.
REQ-012 SHALL have port: fifo_push  out  1  push strobe to the shared FIFO.
REQ-013 SHALL have port: fifo_data  out  DATA_W  write data to the shared FIFO.
REQ-014 SHALL have port: timeout  out  1  one-cycle pulse on forced release; tied 0 without the macro.

Function
REQ-015 SHALL implement a one-hot state machine with states IDLE, GNT_0 and GNT_1.
REQ-016 In IDLE, SHALL grant the single active requester, or on simultaneous req_0 and req_1 the requester not named by rr_ptr; gnt_n asserts the cycle after the request is sampled.
REQ-017 SHALL derive fifo_push = push_n & ~fifo_full and fifo_data = data_n combinationally from the granted requester; fifo_push = 0 and fifo_data = 0 in IDLE.
REQ-018 SHALL drive full_n = fifo_full for the granted requester and full_n = 1 for the other requester and for both in IDLE.
REQ-019 SHALL define an accepted push as fifo_push = 1; push_n from a requester without grant SHALL be ignored.
REQ-020 On an accepted push with last_n = 1, SHALL set rr_ptr to n and re-arbitrate in the same cycle (other requester preferred); the next grant SHALL be visible the following cycle with no IDLE bubble.
REQ-021 If req_n drops while GNT_n and no accepted last push occurs, SHALL move to IDLE next cycle and set rr_ptr to n.
REQ-022 While fifo_full = 1, SHALL keep the grant and state unchanged; push_n is not accepted, and the requester holds its data.
REQ-023 SHALL never assert gnt_0 and gnt_1 together, and SHALL never assert fifo_push outside GNT_0 or GNT_1.

Reset
REQ-024 On reset, SHALL asynchronously set state = IDLE and rr_ptr = 1 (requester 0 wins the first tie), and clear the timeout counter.
REQ-025 On reset, SHALL drive gnt_0 = gnt_1 = 0, fifo_push = 0, fifo_data = 0, full_0 = full_1 = 1 and timeout = 0.
REQ-026 On reset asserted mid-burst, SHALL drop the burst; no recovery of partial bursts.

Configuration
REQ-027 With RAW_ARB_TIMEOUT_EN defined, SHALL count GNT cycles with fifo_full = 0 and push_n = 0, and clear the count on any accepted push or on a grant change.
REQ-028 With RAW_ARB_TIMEOUT_EN defined and a count of TIMEOUT_CYCLES, SHALL release to IDLE, pulse timeout for one cycle and set rr_ptr to the timed-out requester.
REQ-029 Without RAW_ARB_TIMEOUT_EN, SHALL omit the counter and tie timeout to 0; grants release only per REQ-020 and REQ-021.

Structure
REQ-030 SHALL place the state encodings, the DATA_W default and the TIMEOUT_CYCLES default in the shared package raw_arb_pkg.
REQ-031 SHALL implement the timeout counter as sub-module raw_arb_wdog, instantiated only under RAW_ARB_TIMEOUT_EN.

Verification
REQ-032 SHALL cover: req_0 = 1 alone, 4 pushes with last on the 4th -> gnt_0 from cycle 1, 4 fifo_push, data order preserved, then IDLE.
REQ-033 SHALL cover: req_0 = req_1 = 1 from reset -> requester 0 granted first, then gnt_1 the cycle after the last_0 push, with no gap.
REQ-034 SHALL cover: fifo_full = 1 for 3 cycles mid-burst -> fifo_push = 0 and full_0 = 1 during the stall, grant held, no word lost or duplicated.
REQ-035 SHALL cover: push_1 = 1 while only gnt_0 is active -> fifo_push follows requester 0 only and full_1 = 1.
REQ-036 SHALL cover: req_0 dropped after 2 pushes -> IDLE next cycle, and a pending req_1 is granted the cycle after.
REQ-037 SHALL cover, with RAW_ARB_TIMEOUT_EN: granted requester idle for 16 cycles -> timeout pulses once, grant released, other requester granted next.
